// File: rtl/spi_slave_rx_tx.sv
// spi_slave_rx_tx
// SPI responder for the byte-counted SPI master. sck, cs_n and mosi are
// oversampled on clk through SYNC_STAGES-deep synchronisers; all four
// {CPOL,CPHA} modes are supported. tx_data is shifted out MSB-first on miso
// while mosi bits are assembled right-aligned into rx_data.
//
// Ports
//   clk        system clock (sck must be <= clk/8)
//   rst_n      asynchronous active-low reset
//   mode       {CPOL,CPHA}, latched at frame start
//   byte_num   frame length in bytes (0 -> 1, >MAX_BYTES -> MAX_BYTES), latched at frame start
//   tx_data    response word, bits [N-1:0] sent MSB first, latched at frame start
//   sck        SPI clock from master (asynchronous)
//   cs_n       chip select, active low (asynchronous)
//   mosi       master-out data (asynchronous)
//   miso       slave-out data
//   miso_oe    miso output enable, high while a frame is open
//   rx_data    received word, right-aligned, held until the next rx_valid
//   rx_valid   one-clk pulse when rx_data takes a complete frame
//   busy       high from frame start until cs_n rises
//   frame_err  one-clk pulse when cs_n rises before all N bits were sampled
module spi_slave_rx_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_BYTES   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [3:0]             byte_num,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  input  logic                   sck,
  input  logic                   cs_n,
  input  logic                   mosi,
  output logic                   miso,
  output logic                   miso_oe,
  output logic [8*MAX_BYTES-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   busy,
  output logic                   frame_err
);

  localparam int W = 8 * MAX_BYTES;
  // byte_num is 4 bits, so at most 15 bytes = 120 bits; 7 bits covers every count
  localparam int CW = 7;
  localparam logic [3:0] MAX_B = 4'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic s_sck, s_cs_n, s_mosi, sck_d, cs_d;
  logic sck_rise, sck_fall, cs_fall, cs_rise;
  logic leading, trailing, sample_edge, shift_edge;

  logic          cpol_q, cpha_q;
  logic [CW-1:0] n_bits, bit_cnt, bit_cnt_inc, tx_left;
  logic [W-1:0]  rx_shift, tx_reg, tx_aligned;
  logic [3:0]    bytes_clamped;
  logic [CW-1:0] n_bits_next, align_sh;

  logic start, do_sample, do_shift, finish, abort, close;

  // cs_n synchroniser resets high so leaving reset never looks like a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= s_sck;
      cs_d      <= s_cs_n;
    end
  end

  assign s_sck    = sck_sync[SYNC_STAGES-1];
  assign s_cs_n   = cs_sync[SYNC_STAGES-1];
  assign s_mosi   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = s_sck & ~sck_d;
  assign sck_fall = ~s_sck & sck_d;
  assign cs_fall  = ~s_cs_n & cs_d;
  assign cs_rise  = s_cs_n & ~cs_d;

  assign leading     = cpol_q ? sck_fall : sck_rise;
  assign trailing    = cpol_q ? sck_rise : sck_fall;
  assign sample_edge = cpha_q ? trailing : leading;
  assign shift_edge  = cpha_q ? leading : trailing;

  always_comb begin
    bytes_clamped = byte_num;
    if (byte_num == 4'd0)
      bytes_clamped = 4'd1;
    else if (byte_num > MAX_B)
      bytes_clamped = MAX_B;
  end

  // Left-align the frame so its bit N-1 sits in the MSB of the tx shifter
  assign n_bits_next = {bytes_clamped, 3'b000};
  assign align_sh    = CW'(W) - n_bits_next;
  assign tx_aligned  = tx_data << align_sh;
  assign bit_cnt_inc = bit_cnt + CW'(1);

  assign busy    = (state != IDLE);
  assign miso_oe = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // A cs_n rise in SHIFT beats a coincident sample edge: the frame is aborted
  always_comb begin
    next_state = state;
    start      = 1'b0;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    close      = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          start      = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else begin
          if (sample_edge) begin
            do_sample = 1'b1;
            if (bit_cnt_inc == n_bits) begin
              finish     = 1'b1;
              next_state = DONE;
            end
          end
          if (shift_edge) do_shift = 1'b1;
        end
      end
      DONE: begin
        if (cs_rise) begin
          close      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // tx_left counts bits still to be driven. CPHA=0 puts bit N-1 on miso at
  // frame start; CPHA=1 waits for the first leading edge to drive it, so both
  // modes then advance exactly one bit per shift edge and hold the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      n_bits    <= '0;
      bit_cnt   <= '0;
      tx_left   <= '0;
      rx_shift  <= '0;
      tx_reg    <= '0;
      miso      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (start) begin
        cpol_q   <= mode[1];
        cpha_q   <= mode[0];
        n_bits   <= n_bits_next;
        bit_cnt  <= '0;
        rx_shift <= '0;
        if (mode[0]) begin
          tx_reg  <= tx_aligned;
          tx_left <= n_bits_next;
          miso    <= 1'b0;
        end else begin
          tx_reg  <= tx_aligned << 1;
          tx_left <= n_bits_next - CW'(1);
          miso    <= tx_aligned[W-1];
        end
      end
      if (do_sample) begin
        rx_shift <= {rx_shift[W-2:0], s_mosi};
        bit_cnt  <= bit_cnt_inc;
      end
      if (finish) begin
        rx_data  <= {rx_shift[W-2:0], s_mosi};
        rx_valid <= 1'b1;
      end
      if (do_shift && (tx_left != '0)) begin
        miso    <= tx_reg[W-1];
        tx_reg  <= tx_reg << 1;
        tx_left <= tx_left - CW'(1);
      end
      if (abort) frame_err <= 1'b1;
      if (abort || close) miso <= 1'b0;
    end
  end

endmodule
